// File: rtl/lift_pkg.sv
// Shared types and constants for the lift share loader and its result FIFO.
package lift_pkg;

  localparam int SHARE_W          = 30;
  localparam int SOP_W            = 4;
  localparam int START_CYC        = 7;
  localparam int FIFO_DEPTH       = 2;
  localparam int TIMEOUT          = 64;
  localparam int NUM_SHARES_SMALL = 6;
  localparam int NUM_SHARES_BIG   = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PAD   = 3'd2,
    ST_ARM   = 3'd3,
    ST_START = 3'd4
  } loader_state_t;

  function automatic logic [2:0] num_shares(input logic big_mode);
    if (big_mode) begin
      num_shares = 3'(NUM_SHARES_BIG);
    end else begin
      num_shares = 3'(NUM_SHARES_SMALL);
    end
  endfunction

endpackage

// File: rtl/lift_share_loader_if.sv
// Share input stream, share RAM write port, sum unit control and result stream.
interface lift_share_loader_if;
  import lift_pkg::*;

  logic               mode;
  logic               in_valid;
  logic               in_ready;
  logic [SHARE_W-1:0] in_data;
  logic [2:0]         ext_addr;
  logic               ext_we;
  logic [SHARE_W-1:0] ext_din;
  logic               sum_mode;
  logic               start;
  logic [SOP_W-1:0]   rounded_sop;
  logic               rounded_sop_write;
  logic               out_valid;
  logic               out_ready;
  logic [SOP_W-1:0]   out_data;

  modport master (
    input  mode, in_valid, in_data, rounded_sop, rounded_sop_write, out_ready,
    output in_ready, ext_addr, ext_we, ext_din, sum_mode, start, out_valid, out_data
  );

  modport slave (
    output mode, in_valid, in_data, rounded_sop, rounded_sop_write, out_ready,
    input  in_ready, ext_addr, ext_we, ext_din, sum_mode, start, out_valid, out_data
  );

endinterface

// File: rtl/lift_share_loader_fifo.sv
// Two-entry result FIFO; a push into a full FIFO is only honoured alongside a pop.
module sop_result_fifo
  import lift_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [SOP_W-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [SOP_W-1:0] head
);

  logic [1:0][SOP_W-1:0] mem_q, mem_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  push_ok, pop_ok;

  // Pointer, storage and occupancy update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop_ok   = pop && (count_q != 2'd0);
    push_ok  = push && ((count_q != 2'(FIFO_DEPTH)) || pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/lift_share_loader.sv
// Loads shares into the sum unit's RAM, runs the start window and queues results.
// Optional macro LIFT_LOADER_TIMEOUT_EN adds a sticky result watchdog (timeout_err).
module lift_share_loader
  import lift_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  lift_share_loader_if.master bus,
  output logic                busy,
  output logic                spurious_err
`ifdef LIFT_LOADER_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);

  loader_state_t      state_q, state_d;
  logic [2:0]         wcnt_q, wcnt_d;
  logic [2:0]         scnt_q, scnt_d;
  logic               sum_mode_q, sum_mode_d;
  logic [1:0]         outstanding_q, outstanding_d;
  logic               spurious_q, spurious_d;
  logic [1:0]         fifo_count;
  logic [SOP_W-1:0]   fifo_head;
  logic               fifo_push, fifo_pop, out_valid_c;
  logic               ready_en, in_ready_c, we_c, start_c, launch;
  logic [2:0]         addr_c;
  logic [SHARE_W-1:0] din_c;

  // The share port is held off while reset is asserted even though IDLE accepts.
  assign ready_en = ~rst;

  // Sequencer next state and share RAM write port.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    scnt_d     = scnt_q;
    sum_mode_d = sum_mode_q;
    in_ready_c = 1'b0;
    we_c       = 1'b0;
    addr_c     = 3'd0;
    din_c      = '0;
    start_c    = 1'b0;
    launch     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_c = ready_en;
        if (bus.in_valid && ready_en) begin
          sum_mode_d = bus.mode;
          we_c       = 1'b1;
          addr_c     = 3'd0;
          din_c      = bus.in_data;
          wcnt_d     = 3'd1;
          state_d    = ST_LOAD;
        end else begin
          wcnt_d = 3'd0;
        end
      end
      ST_LOAD: begin
        in_ready_c = ready_en;
        if (bus.in_valid && ready_en) begin
          we_c   = 1'b1;
          addr_c = wcnt_q;
          din_c  = bus.in_data;
          wcnt_d = wcnt_q + 3'd1;
          if ((wcnt_q + 3'd1) == num_shares(sum_mode_q)) begin
            state_d = sum_mode_q ? ST_ARM : ST_PAD;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_PAD: begin
        // Small lift leaves slot 6 unused; zero it so the sum is deterministic.
        we_c    = 1'b1;
        addr_c  = 3'(NUM_SHARES_BIG - 1);
        din_c   = '0;
        state_d = ST_ARM;
      end
      ST_ARM: begin
        if (({1'b0, outstanding_q} + {1'b0, fifo_count}) < 3'(FIFO_DEPTH)) begin
          scnt_d  = 3'd0;
          state_d = ST_START;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_START: begin
        start_c = 1'b1;
        if (scnt_q == 3'(START_CYC - 1)) begin
          launch  = 1'b1;
          scnt_d  = 3'd0;
          state_d = ST_IDLE;
        end else begin
          scnt_d = scnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result tracking: credits out when a window ends, back in on each strobe.
  always_comb begin
    fifo_push     = bus.rounded_sop_write && (outstanding_q != 2'd0);
    out_valid_c   = (fifo_count != 2'd0);
    fifo_pop      = out_valid_c && bus.out_ready;
    outstanding_d = outstanding_q + {1'b0, launch} - {1'b0, fifo_push};
    spurious_d    = spurious_q | (bus.rounded_sop_write && (outstanding_q == 2'd0));
  end

  // Sequencer and credit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wcnt_q        <= 3'd0;
      scnt_q        <= 3'd0;
      sum_mode_q    <= 1'b0;
      outstanding_q <= 2'd0;
      spurious_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      scnt_q        <= scnt_d;
      sum_mode_q    <= sum_mode_d;
      outstanding_q <= outstanding_d;
      spurious_q    <= spurious_d;
    end
  end

  sop_result_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (bus.rounded_sop),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

`ifdef LIFT_LOADER_TIMEOUT_EN
  logic [6:0] tcnt_q, tcnt_d;
  logic       timeout_q, timeout_d;

  // Watchdog: counts while results are owed, restarts on every strobe.
  always_comb begin
    if (bus.rounded_sop_write) begin
      tcnt_d = 7'd0;
    end else if (outstanding_q != 2'd0) begin
      if (tcnt_q != 7'(TIMEOUT)) begin
        tcnt_d = tcnt_q + 7'd1;
      end else begin
        tcnt_d = tcnt_q;
      end
    end else begin
      tcnt_d = 7'd0;
    end
    timeout_d = timeout_q | (tcnt_d == 7'(TIMEOUT));
  end

  // Watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q    <= 7'd0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.ext_we    = we_c;
  assign bus.ext_addr  = addr_c;
  assign bus.ext_din   = din_c;
  assign bus.start     = start_c;
  assign bus.sum_mode  = sum_mode_q;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = fifo_head;
  assign busy          = (state_q != ST_IDLE) || (outstanding_q != 2'd0) || out_valid_c;
  assign spurious_err  = spurious_q;

endmodule

// File: tb/tb_lift_share_loader.sv
// Bench for lift_share_loader: the bench plays share source, sum unit and result sink.
module tb_lift_share_loader;
  import lift_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy, spurious_err;
`ifdef LIFT_LOADER_TIMEOUT_EN
  logic timeout_err;
`endif

  always #5 clk = ~clk;

  lift_share_loader_if bus ();

  lift_share_loader dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .spurious_err (spurious_err)
`ifdef LIFT_LOADER_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_ready = 1'b0;

  // Observed traffic
  logic [32:0] wr_q[$];
  int          runs_q[$];
  bit          run_mode_q[$];
  logic [3:0]  got_q[$];
  int          run_len = 0;
  bit          run_mode;
  int          glitch = 0;
  int          valid_cycles = 0;

  // Reference model expectations
  logic [32:0] exp_wr[$];
  logic [3:0]  exp_sop[$];

  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else begin
      if (bus.ext_we) wr_q.push_back({bus.ext_addr, bus.ext_din});
      if (bus.start) begin
        if (run_len == 0) run_mode = bus.sum_mode;
        else if (bus.sum_mode != run_mode) glitch++;
        run_len++;
      end else if (run_len != 0) begin
        runs_q.push_back(run_len);
        run_mode_q.push_back(run_mode);
        run_len = 0;
      end
      if (bus.out_valid) valid_cycles++;
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear();
    wr_q.delete(); runs_q.delete(); run_mode_q.delete(); got_q.delete();
    exp_wr.delete(); exp_sop.delete();
    valid_cycles = 0;
  endtask

  // Model: a coefficient writes its shares at 0..n-1; a small lift also zeroes slot 6.
  task automatic exp_coeff(input bit m, input logic [29:0] d [7]);
    int n = m ? NUM_SHARES_BIG : NUM_SHARES_SMALL;
    for (int i = 0; i < n; i++) exp_wr.push_back({3'(i), d[i]});
    if (!m) exp_wr.push_back({3'd6, 30'd0});
  endtask

  function automatic int wr_mism();
    int m = 0;
    if (wr_q.size() != exp_wr.size()) return 1000;
    for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== exp_wr[i]) m++;
    return m;
  endfunction

  task automatic send_coeff(input bit m, input logic [29:0] d [7], output bit ok);
    int n = m ? NUM_SHARES_BIG : NUM_SHARES_SMALL;
    int w;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      bus.mode     = (i == 0) ? m : 1'($urandom_range(0, 1));
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (!bus.in_ready) ok = 1'b0;
      tick();
      if (!ok) break;
    end
    bus.in_valid = 1'b0;
    bus.mode     = ~m;
  endtask

  task automatic wait_runs(input int target, output bit ok);
    int w = 0;
    while (runs_q.size() < target && w < 400) begin
      tick();
      w++;
    end
    ok = (runs_q.size() >= target);
  endtask

  task automatic strobe(input logic [3:0] v);
    bus.rounded_sop       = v;
    bus.rounded_sop_write = 1'b1;
    tick();
    bus.rounded_sop_write = 1'b0;
  endtask

  task automatic drain(input int n);
    int w = 0;
    bus.out_ready = 1'b1;
    while (got_q.size() < n && w < 100) begin
      tick();
      w++;
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 30'h155; bus.mode = 1'b1;
    bus.rounded_sop = 4'h0; bus.rounded_sop_write = 1'b0; bus.out_ready = 1'b1;
    ticks(3);
    n_checks++;
    if ({bus.in_ready, bus.ext_we, bus.start, bus.out_valid, busy, spurious_err, bus.sum_mode} !== 7'b0)
      $display("FAIL rst_flags got=%b exp=0000000",
               {bus.in_ready, bus.ext_we, bus.start, bus.out_valid, busy, spurious_err, bus.sum_mode});
    else n_pass++;
    n_checks++;
    if ({bus.ext_addr, bus.ext_din, bus.out_data} !== 37'd0)
      $display("FAIL rst_data got addr=%0d din=%h out=%h exp=0", bus.ext_addr, bus.ext_din, bus.out_data);
    else n_pass++;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL idle_ready got=%b exp=1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_big();
    logic [29:0] d [7];
    bit ok;
    clear();
    for (int i = 0; i < 7; i++) d[i] = 30'(i + 1);
    exp_coeff(1'b1, d);
    send_coeff(1'b1, d, ok);
    wait_runs(1, ok);
    n_checks++;
    if (!ok) $display("FAIL big_done got=no_window exp=window"); else n_pass++;
    n_checks++;
    if (wr_mism() != 0) $display("FAIL big_writes got=%p exp=%p", wr_q, exp_wr); else n_pass++;
    n_checks++;
    if (runs_q[0] !== START_CYC || run_mode_q[0] !== 1'b1)
      $display("FAIL big_start got=%0d/%0b exp=7/1", runs_q[0], run_mode_q[0]);
    else n_pass++;
    bus.out_ready = 1'b1;
    valid_cycles = 0;
    strobe(4'hA);
    ticks(4);
    bus.out_ready = 1'b0;
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 4'hA)
      $display("FAIL big_result got=%p exp='{10}", got_q);
    else n_pass++;
    n_checks++;
    if (valid_cycles != 1 || busy !== 1'b0)
      $display("FAIL big_valid got=%0d/busy%b exp=1/busy0", valid_cycles, busy);
    else n_pass++;
  endtask

  task automatic test_small();
    logic [29:0] d [7];
    bit ok;
    clear();
    for (int i = 0; i < 7; i++) d[i] = 30'(16 + i);
    exp_coeff(1'b0, d);
    send_coeff(1'b0, d, ok);
    wait_runs(1, ok);
    n_checks++;
    if (wr_mism() != 0 || !ok) $display("FAIL small_writes got=%p exp=%p", wr_q, exp_wr); else n_pass++;
    n_checks++;
    if (runs_q[0] !== START_CYC || run_mode_q[0] !== 1'b0 || bus.sum_mode !== 1'b0)
      $display("FAIL small_start got=%0d/%0b/%0b exp=7/0/0", runs_q[0], run_mode_q[0], bus.sum_mode);
    else n_pass++;
    strobe(4'h6);
    drain(1);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 4'h6) $display("FAIL small_result got=%p exp='{6}", got_q);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [29:0] d [7];
    bit ok, m;
    clear();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      m = (c == 1) ? 1'b0 : 1'b1;
      for (int i = 0; i < 7; i++) d[i] = 30'($urandom);
      exp_coeff(m, d);
      send_coeff(m, d, ok);
      if (c < 2) begin
        wait_runs(c + 1, ok);
        strobe((c == 0) ? 4'd3 : 4'd5);
      end
    end
    ticks(20);
    n_checks++;
    if (runs_q.size() != 2 || bus.start !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_stall got=%0d windows exp=2", runs_q.size());
    else n_pass++;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd3)
      $display("FAIL b2b_head got=%b/%0d exp=1/3", bus.out_valid, bus.out_data);
    else n_pass++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    wait_runs(3, ok);
    n_checks++;
    if (!ok) $display("FAIL b2b_resume got=%0d windows exp=3", runs_q.size()); else n_pass++;
    strobe(4'd9);
    drain(3);
    n_checks++;
    if (got_q.size() != 3 || got_q[0] !== 4'd3 || got_q[1] !== 4'd5 || got_q[2] !== 4'd9)
      $display("FAIL b2b_order got=%p exp='{3,5,9}", got_q);
    else n_pass++;
    n_checks++;
    if (wr_mism() != 0) $display("FAIL b2b_writes mism=%0d exp=0", wr_mism()); else n_pass++;
  endtask

  task automatic test_mode_switch();
    logic [29:0] d [7];
    bit ok;
    clear();
    for (int i = 0; i < 7; i++) d[i] = 30'($urandom);
    send_coeff(1'b1, d, ok);
    wait_runs(1, ok);
    bus.mode = 1'b0;
    ticks(5);
    n_checks++;
    if (bus.sum_mode !== 1'b1) $display("FAIL ms_hold_idle got=%b exp=1", bus.sum_mode); else n_pass++;
    strobe(4'h1);
    send_coeff(1'b0, d, ok);
    wait_runs(2, ok);
    strobe(4'h2);
    drain(2);
    n_checks++;
    if (run_mode_q.size() != 2 || run_mode_q[0] !== 1'b1 || run_mode_q[1] !== 1'b0 || glitch != 0)
      $display("FAIL ms_windows got=%p glitch=%0d exp='{1,0} glitch=0", run_mode_q, glitch);
    else n_pass++;
  endtask

  task automatic test_spurious();
    clear();
    n_checks++;
    if (spurious_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL sp_pre got=%b/%b exp=0/0", spurious_err, busy);
    else n_pass++;
    strobe(4'h7);
    tick();
    n_checks++;
    if (spurious_err !== 1'b1) $display("FAIL sp_set got=%b exp=1", spurious_err); else n_pass++;
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL sp_fifo got=%b/%b exp=0/0", bus.out_valid, busy);
    else n_pass++;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    n_checks++;
    if (spurious_err !== 1'b0) $display("FAIL sp_clear got=%b exp=0", spurious_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [29:0] d [7];
    bit ok;
    int w = 0;
    clear();
    for (int i = 0; i < 7; i++) d[i] = 30'($urandom);
    send_coeff(1'b1, d, ok);
    wait_runs(1, ok);
    strobe(4'h4);
    send_coeff(1'b1, d, ok);
    while (bus.start !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    ticks(3);
    n_checks++;
    if (bus.start !== 1'b1 || bus.out_valid !== 1'b1)
      $display("FAIL rm_pre got=%b/%b exp=1/1", bus.start, bus.out_valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.start, bus.ext_we, bus.out_valid, busy} !== 4'b0)
      $display("FAIL rm_async got=%b exp=0000", {bus.start, bus.ext_we, bus.out_valid, busy});
    else n_pass++;
    tick(); rst = 1'b0; tick();
    clear();
    for (int i = 0; i < 7; i++) d[i] = 30'($urandom);
    exp_coeff(1'b1, d);
    send_coeff(1'b1, d, ok);
    wait_runs(1, ok);
    n_checks++;
    if (!ok || wr_mism() != 0 || runs_q[0] !== START_CYC)
      $display("FAIL rm_reload got=%p exp=%p", wr_q, exp_wr);
    else n_pass++;
    strobe(4'hC);
    drain(1);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 4'hC || spurious_err !== 1'b0)
      $display("FAIL rm_result got=%p spur=%b exp='{12} spur=0", got_q, spurious_err);
    else n_pass++;
  endtask

`ifdef LIFT_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    logic [29:0] d [7];
    bit ok;
    clear();
    for (int i = 0; i < 7; i++) d[i] = 30'($urandom);
    send_coeff(1'b1, d, ok);
    wait_runs(1, ok);
    ticks(30);
    n_checks++;
    if (timeout_err !== 1'b0) $display("FAIL to_early got=%b exp=0", timeout_err); else n_pass++;
    ticks(40);
    n_checks++;
    if (timeout_err !== 1'b1) $display("FAIL to_set got=%b exp=1", timeout_err); else n_pass++;
    strobe(4'h0);
    drain(1);
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask
`endif

  task automatic test_random();
    logic [29:0] d [7];
    logic [3:0]  v;
    bit ok, m;
    clear();
    rand_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      m = 1'($urandom_range(0, 1));
      for (int i = 0; i < 7; i++) d[i] = 30'($urandom);
      wr_q.delete();
      exp_wr.delete();
      exp_coeff(m, d);
      send_coeff(m, d, ok);
      wait_runs(k + 1, ok);
      n_checks++;
      if (!ok || wr_mism() != 0) $display("FAIL rnd_writes_%0d got=%p exp=%p", k, wr_q, exp_wr);
      else n_pass++;
      n_checks++;
      if (runs_q[k] !== START_CYC || run_mode_q[k] !== m)
        $display("FAIL rnd_start_%0d got=%0d/%0b exp=7/%0b", k, runs_q[k], run_mode_q[k], m);
      else n_pass++;
      ticks($urandom_range(0, 4));
      v = 4'($urandom);
      exp_sop.push_back(v);
      strobe(v);
    end
    rand_ready = 1'b0;
    drain(10);
    n_checks++;
    if (got_q != exp_sop) $display("FAIL rnd_results got=%p exp=%p", got_q, exp_sop);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_big();
    test_small();
    test_back_to_back();
    test_mode_switch();
    test_spurious();
    test_reset_mid();
`ifdef LIFT_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lift_share_loader.md
Name: lift_share_loader

Overview:
- Initiator-side sequencer for the fixed-point sum-of-products lift unit.
- Accepts a stream of 30-bit scaled residue shares per coefficient (6 for small lift, 7 for big lift).
- Writes the shares into the sum unit's share RAM over its ext_addr/ext_we/ext_din port, then drives the start window.
- Collects the 4-bit rounded result on the rounded_sop_write strobe and returns it over a valid/ready output with a 2-entry result FIFO.

Parameters:
- SHARE_W, 30, share data width.
- SOP_W, 4, rounded result width.
- START_CYC, 7, start-high window length; covers sum read addresses 0..6.
- FIFO_DEPTH, 2, result FIFO entries; this is also the credit limit.
- TIMEOUT, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mode  in  1  0 = small lift (6 shares), 1 = big lift (7 shares); sampled on first accepted share
- in_valid  in  1  share valid
- in_ready  out  1  share accepted when in_valid && in_ready
- in_data  in  30  scaled share, presented in address order 0,1,...
- ext_addr  out  3  share RAM write address
- ext_we  out  1  share RAM write enable
- ext_din  out  30  share RAM write data
- sum_mode  out  1  mode driven to sum unit
- start  out  1  sum unit start
- rounded_sop  in  4  sum unit result
- rounded_sop_write  in  1  sum unit result strobe (single cycle, no backpressure)
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  4  rounded result
- busy  out  1  state != IDLE or outstanding != 0 or FIFO not empty
- spurious_err  out  1  sticky; strobe arrived with outstanding == 0

Behaviour:
- Reset values:
  - Registers: state = IDLE; wcnt = 0; outstanding = 0; FIFO empty; spurious_err = 0; sum_mode = 0.
  - Outputs: in_ready, ext_we, start, out_valid, busy all 0; ext_addr = 0; ext_din = 0; out_data = 0.
- FSM states: IDLE, LOAD, PAD, ARM, START.
- IDLE:
  - in_ready = 1.
  - On accept: latch mode into sum_mode; write the share at addr 0; wcnt = 1; go to LOAD.
- LOAD:
  - in_ready = 1.
  - Each accept drives ext_we = 1, ext_addr = wcnt, ext_din = in_data in the same cycle (combinational path from accept), then wcnt++.
  - After the last share (wcnt reaches 6 in mode 0, 7 in mode 1): mode 0 goes to PAD, mode 1 goes to ARM.
- PAD:
  - in_ready = 0.
  - One cycle with ext_we = 1, ext_addr = 6, ext_din = 0, so the unused slot 6 is deterministic.
  - Then go to ARM.
- ARM:
  - in_ready = 0.
  - Wait until credit is available: outstanding + fifo_count < FIFO_DEPTH.
  - Then go to START.
- START:
  - start = 1 for exactly START_CYC consecutive cycles; in_ready = 0; sum_mode held.
  - On leaving START, outstanding increments (same cycle as the last start cycle) and state returns to IDLE.
  - The next coefficient's load may then overlap the previous result's latency.
- sum_mode changes only on the first accept in IDLE, so it is stable through all writes and the full start window.
- Result path:
  - rounded_sop_write with outstanding > 0: push rounded_sop into the FIFO and decrement outstanding.
  - Credit rule guarantees the FIFO never overflows.
  - Strobe with outstanding == 0: ignored, spurious_err set.
  - Increment and decrement of outstanding in the same cycle leaves it unchanged.
  - FIFO push and pop in the same cycle are both honoured.
- Output:
  - out_valid = FIFO not empty; out_data = FIFO head (registered).
  - Results are returned in coefficient order; there is no fixed latency, and delivery is counted only by strobes.
- Reset mid-operation: everything returns to reset values immediately and in-flight results are dropped. The sum unit is reset with the same rst.

Optional Feature:
- Macro: LIFT_LOADER_TIMEOUT_EN.
- Defined:
  - Adds output timeout_err (1 bit, sticky, reset 0).
  - A counter runs while outstanding > 0 and clears on each strobe.
  - Reaching TIMEOUT sets timeout_err.
- Undefined: no port, no counter; behaviour is otherwise identical.

Decomposition:
- Shared package lift_pkg:
  - SHARE_W, SOP_W, START_CYC, NUM_SHARES_SMALL = 6, NUM_SHARES_BIG = 7.
  - State enum loader_state_t.
- Sub-module sop_result_fifo: 2-entry, 4-bit synchronous FIFO with push/pop/count, async reset.

Test Plan:
- Big mode, shares 0x1..0x7, out_ready = 1 → ext writes at addr 0..6 with the same data, start high 7 cycles, strobe with sop = 0xA → out_data = 0xA, out_valid one cycle.
- Small mode, shares 0x10..0x15 → writes addr 0..5, then addr 6 with 0 (PAD), then start for 7 cycles; sum_mode = 0 throughout.
- Back-to-back 3 coefficients, out_ready = 0, strobes returned with sop 3, 5 → third coefficient stalls in ARM until a pop. Pop yields 3, then 5; third then starts and returns 9.
- Mode switch: coefficient in mode 1 then mode 0 → sum_mode flips only at the first accept of the second load, never inside a start window.
- Strobe with outstanding = 0 → spurious_err = 1 and FIFO unchanged; rst pulse clears it.
- Reset asserted in START cycle 4 → start, ext_we, out_valid low immediately; outstanding = 0; a new big-mode load completes normally. With LIFT_LOADER_TIMEOUT_EN, withholding the strobe for 64 cycles → timeout_err = 1.
